ss_stream_tx: RTL

// - Transmit side of the 2-bit stochastic-symbol link: converts one 9-bit binary operand into a frame of FRAME_LEN 2-bit symbols.
// - Symbols are generated from an internal 8-bit LFSR.
// - Sits upstream of the stochastic MAC. Accumulating one full FRAME_LEN=128 frame at the receiver reproduces the operand (sum ~= x).
// - Valid/ready on both the operand input and the symbol output.

---
 rtl/ss_stream_tx.sv | 99 +++++++++
 1 files changed

// File: rtl/ss_stream_tx.sv
// rtl/ss_stream_tx.sv - stochastic-symbol link transmitter: 9-bit operand to a frame of 2-bit symbols
module ss_stream_tx #(
    parameter int unsigned FRAME_LEN = 128,
    parameter logic [7:0]  SEED      = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [8:0] in_x,
    input  logic       abort,
    input  logic       seed_load,
    input  logic [7:0] seed_in,
    output logic       ss_valid,
    input  logic       ss_ready,
    output logic [1:0] ss_data,
    output logic       ss_last,
    output logic       busy
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // cnt is 8 bits wide because a frame never exceeds 256 symbols
    localparam logic [7:0] LAST_CNT = 8'(FRAME_LEN - 1);
    localparam logic [8:0] X_MAX    = 9'd384;

    state_t     state;
    state_t     state_nxt;
    logic [8:0] x_reg;
    logic [7:0] cnt;
    logic [7:0] lfsr;
    logic       accept;
    logic       xfer;
    logic       gt;
    logic [1:0] sym;

    // Next state, handshakes and the combinational symbol derived from registers
    always_comb begin
        state_nxt = state;
        in_ready  = (state == IDLE);
        ss_valid  = (state == RUN);
        busy      = (state == RUN);
        ss_last   = (state == RUN) && (cnt == LAST_CNT);
        // an abort cancels both the operand accept and the symbol transfer of its cycle
        accept    = in_ready && in_valid && !abort;
        xfer      = ss_valid && ss_ready && !abort;
        // clamp guarantees x_reg[8:7]==3 only with x_reg[6:0]==0, so the add cannot wrap
        gt        = (x_reg[6:0] > lfsr[6:0]);
        sym       = x_reg[8:7] + {1'b0, gt};
        ss_data   = ss_valid ? sym : 2'd0;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (in_valid) state_nxt = RUN;
                RUN:  if (ss_ready && ss_last) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand, beat counter and LFSR; the LFSR deliberately carries over between frames
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_reg <= 9'd0;
            cnt   <= 8'd0;
            lfsr  <= SEED;
        end else begin
            if (accept) begin
                x_reg <= (in_x > X_MAX) ? X_MAX : in_x;
            end

            if (abort || accept) begin
                cnt <= 8'd0;
            end else if (xfer) begin
                cnt <= ss_last ? 8'd0 : cnt + 8'd1;
            end

            if (seed_load) begin
                lfsr <= (seed_in != 8'd0) ? seed_in : SEED;
            end else if (xfer) begin
                lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            end
        end
    end

endmodule
